// File: rtl/board_mem_arbiter_if.sv
// Bus bundle for board_mem_arbiter: display read port, game r/w port
// and the single-port cell RAM side.
interface board_mem_arbiter_if #(
  parameter int X_BITS    = 4,
  parameter int Y_BITS    = 4,
  parameter int DATA_BITS = 8
);
  logic                      disp_req;
  logic [X_BITS-1:0]         disp_x;
  logic [Y_BITS-1:0]         disp_y;
  logic                      disp_valid;
  logic [DATA_BITS-1:0]      disp_data;
  logic                      disp_drop;
  logic                      game_req;
  logic                      game_we;
  logic [X_BITS-1:0]         game_x;
  logic [Y_BITS-1:0]         game_y;
  logic [DATA_BITS-1:0]      game_wdata;
  logic                      game_ack;
  logic [DATA_BITS-1:0]      game_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [Y_BITS+X_BITS-1:0]  mem_addr;
  logic [DATA_BITS-1:0]      mem_wdata;
  logic [DATA_BITS-1:0]      mem_rdata;

  modport slave (
    input  disp_req, disp_x, disp_y,
    input  game_req, game_we, game_x, game_y, game_wdata,
    input  mem_rdata,
    output disp_valid, disp_data, disp_drop,
    output game_ack, game_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_x, disp_y,
    output game_req, game_we, game_x, game_y, game_wdata,
    output mem_rdata,
    input  disp_valid, disp_data, disp_drop,
    input  game_ack, game_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Single-port cell RAM arbiter: display reads have priority, game
// accesses are forced ahead after STARVE_LIMIT lost cycles.
module board_mem_arbiter #(
  parameter int X_BITS       = 4,
  parameter int Y_BITS       = 4,
  parameter int DATA_BITS    = 8,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  board_mem_arbiter_if.slave bus
);

  localparam int A_BITS = X_BITS + Y_BITS;
  localparam int C_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [C_BITS-1:0] LIMIT = C_BITS'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;

  state_e                state_q, state_d;
  logic                  slot_q, slot_d;
  logic [A_BITS-1:0]     slot_addr_q, slot_addr_d;
  logic [C_BITS-1:0]     starve_q, starve_d;
  logic                  own_game_q, own_game_d;
  logic                  is_wr_q, is_wr_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [A_BITS-1:0]     addr_q, addr_d;
  logic [DATA_BITS-1:0]  wdata_q, wdata_d;
  logic                  dvalid_q, dvalid_d;
  logic [DATA_BITS-1:0]  ddata_q, ddata_d;
  logic                  drop_q, drop_d;
  logic                  ack_q, ack_d;
  logic [DATA_BITS-1:0]  rdata_q, rdata_d;

  logic                  game_ok;
  logic                  disp_avail;
  logic                  grant_game;
  logic                  grant_disp;
  logic [A_BITS-1:0]     disp_addr;

  assign disp_addr  = {bus.disp_y, bus.disp_x};
  // The ack cycle blocks regrant of a request still held by the game FSM.
  assign game_ok    = bus.game_req & ~ack_q;
  assign disp_avail = slot_q | bus.disp_req;

  always_comb begin
    grant_game = 1'b0;
    grant_disp = 1'b0;
    if (state_q == IDLE) begin
      if (game_ok && starve_q >= LIMIT) grant_game = 1'b1;
      else if (disp_avail)              grant_disp = 1'b1;
      else if (game_ok)                 grant_game = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    slot_addr_d = slot_addr_q;
    starve_d    = starve_q;
    own_game_d  = own_game_q;
    is_wr_d     = is_wr_q;
    en_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dvalid_d    = 1'b0;
    ddata_d     = ddata_q;
    drop_d      = 1'b0;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;

    if (grant_disp) begin
      if (slot_q) begin
        slot_d = bus.disp_req;
        if (bus.disp_req) slot_addr_d = disp_addr;
      end
    end else if (bus.disp_req) begin
      slot_d      = 1'b1;
      slot_addr_d = disp_addr;
      drop_d      = slot_q;
    end

    if (grant_game) starve_d = '0;
    else if (game_ok && starve_q < LIMIT)
      starve_d = starve_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (grant_game) begin
          en_d       = 1'b1;
          we_d       = bus.game_we;
          addr_d     = {bus.game_y, bus.game_x};
          wdata_d    = bus.game_wdata;
          own_game_d = 1'b1;
          is_wr_d    = bus.game_we;
          state_d    = ISSUE;
        end else if (grant_disp) begin
          en_d       = 1'b1;
          addr_d     = slot_q ? slot_addr_q : disp_addr;
          wdata_d    = '0;
          own_game_d = 1'b0;
          is_wr_d    = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (is_wr_q) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (own_game_q) begin
          ack_d   = 1'b1;
          rdata_d = bus.mem_rdata;
        end else begin
          dvalid_d = 1'b1;
          ddata_d  = bus.mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= 1'b0;
      slot_addr_q <= '0;
      starve_q    <= '0;
      own_game_q  <= 1'b0;
      is_wr_q     <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dvalid_q    <= 1'b0;
      ddata_q     <= '0;
      drop_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      slot_addr_q <= slot_addr_d;
      starve_q    <= starve_d;
      own_game_q  <= own_game_d;
      is_wr_q     <= is_wr_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dvalid_q    <= dvalid_d;
      ddata_q     <= ddata_d;
      drop_q      <= drop_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.mem_en     = en_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.disp_valid = dvalid_q;
  assign bus.disp_data  = ddata_q;
  assign bus.disp_drop  = drop_q;
  assign bus.game_ack   = ack_q;
  assign bus.game_rdata = rdata_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: vector table plus multi-cycle
// sequences for starvation, drop, priority and async reset.
module tb_board_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_mem_arbiter_if #(.X_BITS(4), .Y_BITS(4), .DATA_BITS(8)) bus ();

  board_mem_arbiter #(
    .X_BITS(4), .Y_BITS(4), .DATA_BITS(8), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] fdat(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // RAM model: unwritten cells read back fdat(addr)
  logic [7:0]   ram [256];
  logic [255:0] wr_v;
  logic [7:0]   ram_q;
  always @(posedge clk) begin
    if (rst) wr_v <= '0;
    else if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]  <= bus.mem_wdata;
        wr_v[bus.mem_addr] <= 1'b1;
      end else begin
        ram_q <= wr_v[bus.mem_addr] ? ram[bus.mem_addr] : fdat(bus.mem_addr);
      end
    end
  end
  assign bus.mem_rdata = ram_q;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string n, input int c,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc%0d got %h want %h", n, c, act, exp);
  endtask

  function automatic logic [36:0] sig();
    return {bus.disp_valid, bus.disp_data, bus.disp_drop, bus.game_ack,
            bus.game_rdata, bus.mem_en, bus.mem_we, bus.mem_addr,
            bus.mem_wdata};
  endfunction

  function automatic logic [36:0] mk(
    input logic dv, input logic [7:0] dd, input logic dr, input logic ak,
    input logic [7:0] gd, input logic en, input logic we,
    input logic [7:0] a, input logic [7:0] wd);
    return {dv, dd, dr, ak, gd, en, we, a, wd};
  endfunction

  task automatic cyc_chk(input string n, input int c,
                         input logic en, input logic [7:0] a,
                         input logic dv, input logic [7:0] dd,
                         input logic ak, input logic [7:0] gd,
                         input logic dr);
    chk({n, "_mem"}, c, {bus.mem_en, bus.mem_en ? bus.mem_addr : 8'h00},
        {en, a});
    chk({n, "_out"}, c,
        {bus.disp_valid, bus.disp_valid ? bus.disp_data : 8'h00,
         bus.game_ack, bus.game_ack ? bus.game_rdata : 8'h00,
         bus.disp_drop},
        {dv, dd, ak, gd, dr});
  endtask

  task automatic idle_in();
    bus.disp_req   = 1'b0;
    bus.disp_x     = '0;
    bus.disp_y     = '0;
    bus.game_req   = 1'b0;
    bus.game_we    = 1'b0;
    bus.game_x     = '0;
    bus.game_y     = '0;
    bus.game_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        dreq;
    logic [3:0]  dx, dy;
    logic        greq, gwe;
    logic [3:0]  gx, gy;
    logic [7:0]  gwd;
    logic [36:0] exp;
  } vec_t;

  vec_t tbl [13];

  logic       en, dv, ak, dr;
  logic [7:0] a, dd, gd;

  initial begin
    tbl[0]  = '{1,3,5, 0,0,0,0,8'h00, mk(0,0,0,0,0, 1,0,8'h53,0)};
    tbl[1]  = '{0,0,0, 0,0,0,0,8'h00, mk(0,0,0,0,0, 0,0,8'h53,0)};
    tbl[2]  = '{0,0,0, 0,0,0,0,8'h00, mk(1,8'h09,0,0,0, 0,0,8'h53,0)};
    tbl[3]  = '{0,0,0, 1,1,15,15,8'hA5,
                mk(0,8'h09,0,0,0, 1,1,8'hFF,8'hA5)};
    tbl[4]  = '{0,0,0, 1,1,15,15,8'hA5,
                mk(0,8'h09,0,1,0, 0,0,8'hFF,8'hA5)};
    tbl[5]  = '{0,0,0, 0,0,0,0,8'h00, mk(0,8'h09,0,0,0, 0,0,8'hFF,8'hA5)};
    tbl[6]  = '{0,0,0, 1,0,15,15,8'h00,
                mk(0,8'h09,0,0,0, 1,0,8'hFF,8'h00)};
    tbl[7]  = '{0,0,0, 1,0,15,15,8'h00,
                mk(0,8'h09,0,0,0, 0,0,8'hFF,8'h00)};
    tbl[8]  = '{0,0,0, 1,0,15,15,8'h00,
                mk(0,8'h09,0,1,8'hA5, 0,0,8'hFF,8'h00)};
    tbl[9]  = '{0,0,0, 0,0,0,0,8'h00,
                mk(0,8'h09,0,0,8'hA5, 0,0,8'hFF,8'h00)};
    tbl[10] = '{1,0,0, 0,0,0,0,8'h00,
                mk(0,8'h09,0,0,8'hA5, 1,0,8'h00,8'h00)};
    tbl[11] = '{0,0,0, 0,0,0,0,8'h00,
                mk(0,8'h09,0,0,8'hA5, 0,0,8'h00,8'h00)};
    tbl[12] = '{0,0,0, 0,0,0,0,8'h00,
                mk(1,8'h5A,0,0,8'hA5, 0,0,8'h00,8'h00)};

    do_reset();
    chk("reset", 0, sig(), '0);

    for (int i = 0; i < 13; i++) begin
      bus.disp_req   = tbl[i].dreq;
      bus.disp_x     = tbl[i].dx;
      bus.disp_y     = tbl[i].dy;
      bus.game_req   = tbl[i].greq;
      bus.game_we    = tbl[i].gwe;
      bus.game_x     = tbl[i].gx;
      bus.game_y     = tbl[i].gy;
      bus.game_wdata = tbl[i].gwd;
      step();
      chk("vec", i, sig(), tbl[i].exp);
    end

    // starvation: display every 3 cycles, game forced in at edge 10
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      idle_in();
      bus.disp_req = (e == 1 || e == 4 || e == 7 || e == 10);
      bus.disp_x   = 4'(e);
      bus.disp_y   = 4'd2;
      bus.game_req = (e <= 12);
      bus.game_x   = 4'd9;
      bus.game_y   = 4'd9;
      step();
      en = 0; a = 0; dv = 0; dd = 0; ak = 0; gd = 0; dr = 0;
      case (e)
        1:  begin en = 1; a = 8'h21; end
        4:  begin en = 1; a = 8'h24; end
        7:  begin en = 1; a = 8'h27; end
        10: begin en = 1; a = 8'h99; end
        13: begin en = 1; a = 8'h2A; end
        3:  begin dv = 1; dd = fdat(8'h21); end
        6:  begin dv = 1; dd = fdat(8'h24); end
        9:  begin dv = 1; dd = fdat(8'h27); end
        12: begin ak = 1; gd = fdat(8'h99); end
        15: begin dv = 1; dd = fdat(8'h2A); end
        default: ;
      endcase
      cyc_chk("starve", e, en, a, dv, dd, ak, gd, dr);
    end

    // overwrite of pending display slot during a game read
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      idle_in();
      bus.game_req = (e <= 3);
      bus.game_x   = 4'd1;
      bus.game_y   = 4'd1;
      bus.disp_req = (e == 2 || e == 3);
      bus.disp_x   = (e == 2) ? 4'd4 : 4'd6;
      bus.disp_y   = (e == 2) ? 4'd4 : 4'd6;
      step();
      en = 0; a = 0; dv = 0; dd = 0; ak = 0; gd = 0; dr = 0;
      case (e)
        1: begin en = 1; a = 8'h11; end
        3: begin ak = 1; gd = fdat(8'h11); dr = 1; end
        4: begin en = 1; a = 8'h66; end
        6: begin dv = 1; dd = fdat(8'h66); end
        default: ;
      endcase
      cyc_chk("drop", e, en, a, dv, dd, ak, gd, dr);
    end

    // simultaneous requests, then held game_req in its ack cycle
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      idle_in();
      bus.disp_req = (e == 1);
      bus.disp_x   = 4'd2;
      bus.disp_y   = 4'd3;
      bus.game_req = (e <= 7);
      bus.game_x   = 4'd5;
      bus.game_y   = 4'd4;
      step();
      en = 0; a = 0; dv = 0; dd = 0; ak = 0; gd = 0; dr = 0;
      case (e)
        1: begin en = 1; a = 8'h32; end
        3: begin dv = 1; dd = fdat(8'h32); end
        4: begin en = 1; a = 8'h45; end
        6: begin ak = 1; gd = fdat(8'h45); end
        default: ;
      endcase
      cyc_chk("prio", e, en, a, dv, dd, ak, gd, dr);
    end

    // async reset while a game read sits in CAPTURE
    do_reset();
    idle_in();
    bus.disp_req = 1'b1;
    bus.disp_x   = 4'd1;
    bus.disp_y   = 4'd2;
    step();
    idle_in();
    step();
    step();
    bus.game_req = 1'b1;
    bus.game_x   = 4'd3;
    bus.game_y   = 4'd3;
    step();
    step();
    #2;
    rst = 1'b1;
    bus.game_req = 1'b0;
    #1;
    chk("async_rst", 0, sig(), '0);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("post_rst", e, {bus.disp_valid, bus.game_ack, bus.mem_en}, 3'b000);
    end
    bus.disp_req = 1'b1;
    bus.disp_x   = 4'd7;
    bus.disp_y   = 4'd8;
    step();
    idle_in();
    step();
    step();
    chk("rst_recover", 0, {bus.disp_valid, bus.disp_data},
        {1'b1, fdat(8'h87)});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
